// File: rtl/instr_line_assembler.sv
// Assembles one wide instruction line from NUM_WORDS sequential narrow memory reads.
// Up to MAX_OUTSTANDING word reads are kept in flight; one line is handled at a time.
module instr_line_assembler #(
  parameter int unsigned LINE_WIDTH      = 128,
  parameter int unsigned WORD_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  line_req_i,
  output logic                  line_gnt_o,
  input  logic [ADDR_WIDTH-1:0] line_addr_i,
  output logic [LINE_WIDTH-1:0] line_r_rdata_o,
  output logic                  line_r_valid_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [WORD_WIDTH-1:0] mem_r_rdata_i,
  input  logic                  mem_r_valid_i
);

  localparam int unsigned NUM_WORDS  = LINE_WIDTH / WORD_WIDTH;
  localparam int unsigned OFFS       = $clog2(LINE_WIDTH / 8);
  localparam int unsigned CNT_W      = $clog2(NUM_WORDS + 1);
  localparam int unsigned WORD_BYTES = WORD_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [CNT_W-1:0]      r_iss_cnt;
  logic [CNT_W-1:0]      r_rsp_cnt;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [LINE_WIDTH-1:0] r_buf;
  logic [LINE_WIDTH-1:0] r_line;

  logic [CNT_W-1:0]      w_outstanding;
  logic                  w_room;
  logic                  w_rsp_ok;
  logic                  w_last_iss;
  logic                  w_last_rsp;
  logic                  w_issue;
  logic                  w_capture;
  logic [ADDR_WIDTH-1:0] w_word_addr;
  logic [LINE_WIDTH-1:0] w_buf_nxt;

  assign w_outstanding = r_iss_cnt - r_rsp_cnt;
  assign w_room        = (w_outstanding < CNT_W'(MAX_OUTSTANDING));
  assign w_rsp_ok      = mem_r_valid_i && (w_outstanding != '0);
  assign w_last_iss    = (r_iss_cnt == CNT_W'(NUM_WORDS - 1));
  assign w_last_rsp    = (r_rsp_cnt == CNT_W'(NUM_WORDS - 1));
  assign w_word_addr   = r_base + ADDR_WIDTH'(r_iss_cnt) * ADDR_WIDTH'(WORD_BYTES);
  assign w_issue       = mem_req_o && mem_gnt_i;
  assign line_r_rdata_o = r_line;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, handshakes and memory request; responses only count while words are in flight.
  always_comb begin
    w_state_nxt    = r_state;
    line_gnt_o     = 1'b0;
    line_r_valid_o = 1'b0;
    mem_req_o      = 1'b0;
    mem_addr_o     = '0;
    w_capture      = 1'b0;
    case (r_state)
      IDLE: begin
        line_gnt_o = line_req_i;
        if (line_req_i) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_req_o  = w_room;
        mem_addr_o = w_room ? w_word_addr : '0;
        w_capture  = w_rsp_ok;
        if (w_room && mem_gnt_i && w_last_iss) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_capture = w_rsp_ok;
        if (w_rsp_ok && w_last_rsp) w_state_nxt = RESP;
      end
      RESP: begin
        line_r_valid_o = 1'b1;
        line_gnt_o     = line_req_i;
        w_state_nxt    = line_req_i ? ISSUE : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_buf_nxt = r_buf;
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      if (r_rsp_cnt == CNT_W'(k)) w_buf_nxt[k*WORD_WIDTH +: WORD_WIDTH] = mem_r_rdata_i;
    end
  end

  // Counters, base address and line buffers; the output line only changes when a line completes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_iss_cnt <= '0;
      r_rsp_cnt <= '0;
      r_base    <= '0;
      r_buf     <= '0;
      r_line    <= '0;
    end else if (line_gnt_o) begin
      r_base    <= {line_addr_i[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
      r_iss_cnt <= '0;
      r_rsp_cnt <= '0;
    end else begin
      if (w_issue) r_iss_cnt <= r_iss_cnt + CNT_W'(1);
      if (w_capture) begin
        r_rsp_cnt <= r_rsp_cnt + CNT_W'(1);
        r_buf     <= w_buf_nxt;
        if (w_last_rsp) r_line <= w_buf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_instr_line_assembler.sv
// Randomized bench for instr_line_assembler: a transaction-level model of the line/memory
// protocol predicts every output each cycle; directed scenarios cover latency, stalls, reset.
module tb_instr_line_assembler;

  localparam int unsigned LW   = 128;
  localparam int unsigned WW   = 32;
  localparam int unsigned AW   = 32;
  localparam int unsigned MAXO = 2;
  localparam int          NW   = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          line_req_i = 1'b0;
  logic          line_gnt_o;
  logic [AW-1:0] line_addr_i = '0;
  logic [LW-1:0] line_r_rdata_o;
  logic          line_r_valid_o;
  logic          mem_req_o;
  logic          mem_gnt_i = 1'b0;
  logic [AW-1:0] mem_addr_o;
  logic [WW-1:0] mem_r_rdata_i = '0;
  logic          mem_r_valid_i = 1'b0;

  instr_line_assembler #(
    .LINE_WIDTH(LW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)
  ) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .line_req_i(line_req_i), .line_gnt_o(line_gnt_o), .line_addr_i(line_addr_i),
    .line_r_rdata_o(line_r_rdata_o), .line_r_valid_o(line_r_valid_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_r_rdata_i(mem_r_rdata_i), .mem_r_valid_i(mem_r_valid_i)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] data;
    int          due;
  } rsp_t;

  int n_checks = 0;
  int n_errors = 0;

  // model of the transaction in flight
  int           cyc = 0;
  bit           m_active = 0;
  logic [31:0]  m_base = '0;
  int           m_iss = 0;
  int           m_rsp = 0;
  int           m_resp_cyc = -1;
  logic [127:0] exp_line = '0;
  logic [127:0] last_line = '0;
  rsp_t         pend_q[$];
  int           last_due = 0;
  logic [31:0]  req_q[$];

  // memory behaviour knobs
  int gnt_pct = 100;
  int dly_min = 1;
  int dly_max = 1;
  int blk_word = -1;
  int blk_left = 0;
  bit stray = 0;
  int data_mode = 0;

  // observations
  int           obs_acc_q[$];
  int           obs_val_q[$];
  logic [127:0] obs_line = '0;
  bit           prev_req = 0;
  bit           prev_gnt = 0;
  logic [31:0]  prev_addr = '0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (data_mode == 0) return 32'hA0 + {30'd0, a[3:2]};
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] addr);
    logic [127:0] l;
    logic [31:0]  b;
    b = {addr[31:4], 4'h0};
    for (int k = 0; k < NW; k++) l[k*32 +: 32] = mem_fn(b + 32'(4 * k));
    return l;
  endfunction

  // One clock cycle: check outputs against the model, then drive the next inputs.
  task automatic step();
    bit          req_e, idle_e, is_resp, mg;
    logic [31:0] addr_e;
    int          due;
    @(negedge clk_i);
    cyc++;
    is_resp = (cyc == m_resp_cyc);
    idle_e  = !m_active;
    req_e   = m_active && (m_iss < NW) && ((m_iss - m_rsp) < int'(MAXO));
    addr_e  = req_e ? m_base + 32'(4 * m_iss) : 32'h0;
    chk("line_r_valid", 128'(line_r_valid_o), 128'(is_resp));
    chk("line_rdata", line_r_rdata_o, last_line);
    chk("mem_req", 128'(mem_req_o), 128'(req_e));
    chk("mem_addr", 128'(mem_addr_o), 128'(addr_e));
    if (prev_req && !prev_gnt) begin
      chk("hold_req", 128'(mem_req_o), 128'(1));
      chk("hold_addr", 128'(mem_addr_o), 128'(prev_addr));
    end
    if (line_r_valid_o) begin
      obs_val_q.push_back(cyc);
      obs_line = line_r_rdata_o;
    end
    mem_r_valid_i = 1'b0;
    mem_r_rdata_i = $urandom;
    if (stray) begin
      mem_r_valid_i = 1'b1;
      stray = 0;
    end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      mem_r_valid_i = 1'b1;
      mem_r_rdata_i = pend_q[0].data;
      void'(pend_q.pop_front());
      m_rsp++;
      if (m_rsp == NW) begin
        m_resp_cyc = cyc + 1;
        m_active   = 0;
        last_line  = exp_line;
      end
    end
    mg = (int'($urandom_range(99)) < gnt_pct);
    if (req_e && m_iss == blk_word && blk_left > 0) begin
      mg = 0;
      blk_left--;
    end
    mem_gnt_i = mg;
    if (req_e && mg) begin
      due = cyc + int'($urandom_range(dly_max, dly_min));
      if (due <= last_due) due = last_due + 1;
      pend_q.push_back('{data: mem_fn(mem_addr_o), due: due});
      last_due = due;
      m_iss++;
    end
    prev_req  = mem_req_o;
    prev_gnt  = mg;
    prev_addr = mem_addr_o;
    if (req_q.size() > 0) begin
      line_req_i  = 1'b1;
      line_addr_i = req_q[0];
    end else begin
      line_req_i  = 1'b0;
      line_addr_i = $urandom;
    end
    #1;
    chk("line_gnt", 128'(line_gnt_o), 128'(line_req_i && idle_e));
    if (line_req_i && idle_e) begin
      m_active = 1;
      m_base   = {line_addr_i[31:4], 4'h0};
      m_iss    = 0;
      m_rsp    = 0;
      exp_line = line_of(line_addr_i);
      obs_acc_q.push_back(cyc);
      void'(req_q.pop_front());
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    cyc++;
    rst_ni        = 1'b0;
    line_req_i    = 1'b0;
    mem_gnt_i     = 1'b0;
    mem_r_valid_i = 1'b0;
    #1;
    chk("rst_line_gnt", 128'(line_gnt_o), 128'(0));
    chk("rst_line_valid", 128'(line_r_valid_o), 128'(0));
    chk("rst_line_rdata", line_r_rdata_o, 128'(0));
    chk("rst_mem_req", 128'(mem_req_o), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr_o), 128'(0));
    m_active   = 0;
    m_resp_cyc = -1;
    last_line  = '0;
    pend_q.delete();
    req_q.delete();
    last_due   = 0;
    prev_req   = 0;
    blk_left   = 0;
    repeat (2) begin
      @(negedge clk_i);
      cyc++;
    end
    rst_ni = 1'b1;
  endtask

  task automatic run_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((req_q.size() > 0 || m_active || pend_q.size() > 0 || cyc < m_resp_cyc) && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_done"}, 128'(n < budget), 128'(1));
  endtask

  initial begin
    logic [31:0] a;
    int          n;
    do_reset();
    repeat (2) step();

    // single line, zero-wait memory
    data_mode = 0; gnt_pct = 100; dly_min = 1; dly_max = 1;
    req_q.push_back(32'h1C00_0014);
    run_idle("t1", 50);
    chk("t1_latency", 128'(obs_val_q[$] - obs_acc_q[$]), 128'(6));
    chk("t1_line", obs_line, 128'h000000A3_000000A2_000000A1_000000A0);

    // grant withheld for three cycles on word 1
    data_mode = 1; blk_word = 1; blk_left = 3;
    req_q.push_back(32'h2000_0048);
    run_idle("t2", 50);
    chk("t2_stalls", 128'(blk_left), 128'(0));
    chk("t2_line", obs_line, line_of(32'h2000_0040));
    blk_word = -1;

    // slow responses hit the outstanding cap
    dly_min = 4; dly_max = 4;
    req_q.push_back(32'h0000_0300);
    run_idle("t3", 60);
    chk("t3_latency", 128'(obs_val_q[$] - obs_acc_q[$]), 128'(12));
    chk("t3_line", obs_line, line_of(32'h0000_0300));

    // back-to-back lines
    dly_min = 1; dly_max = 1;
    req_q.push_back(32'h0000_0100);
    req_q.push_back(32'h0000_0200);
    run_idle("t4", 60);
    chk("t4_b2b_gnt", 128'(obs_acc_q[$] - obs_val_q[$-1]), 128'(0));
    chk("t4_throughput", 128'(obs_val_q[$] - obs_val_q[$-1]), 128'(6));
    chk("t4_line", obs_line, line_of(32'h0000_0200));

    // reset while two responses are still pending
    dly_min = 4; dly_max = 4;
    req_q.push_back(32'h0000_0400);
    n = 0;
    while (!(m_active && m_iss == NW && pend_q.size() == 2) && n < 40) begin
      step();
      n++;
    end
    chk("t5_reach_drain", 128'(n < 40), 128'(1));
    do_reset();
    dly_min = 1; dly_max = 1;
    req_q.push_back(32'h0000_0504);
    run_idle("t5", 50);
    chk("t5_line", obs_line, line_of(32'h0000_0500));

    // stray response while idle
    stray = 1;
    repeat (2) step();
    req_q.push_back(32'h0000_0600);
    run_idle("t6", 50);
    chk("t6_line", obs_line, line_of(32'h0000_0600));

    // random traffic
    gnt_pct = 60; dly_min = 1; dly_max = 5;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      req_q.push_back(a);
      if ($urandom_range(1) == 1) begin
        a = $urandom;
        req_q.push_back(a);
      end
      run_idle("rnd", 200);
      chk("rnd_line", obs_line, line_of(a));
      repeat ($urandom_range(2)) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
